// File: rtl/mips_pkg.sv
// Shared constants and types for the EX-stage operand forwarding controller.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package mips_pkg;

  localparam int REG_ADDR = 5;
  localparam int SEL_W    = 2;

  // EX operand mux input codes
  localparam logic [SEL_W-1:0] SEL_REGFILE = 2'b00;
  localparam logic [SEL_W-1:0] SEL_MEM     = 2'b01;
  localparam logic [SEL_W-1:0] SEL_WB      = 2'b10;
  localparam logic [SEL_W-1:0] SEL_LATE    = 2'b11;

  // Destination-register history for one pipeline stage
  typedef struct packed {
    logic                valid;
    logic                wr;
    logic                ld;
    logic [REG_ADDR-1:0] rd;
  } trk_t;

  localparam trk_t TRK_NONE = '0;

  // A stage can supply a source when it really writes that register; $0 never forwards
  function automatic logic trk_hit(input trk_t e, input logic [REG_ADDR-1:0] src);
    return e.valid & e.wr & (e.rd == src) & (src != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_ctrl_if.sv
// ID-stage request / EX-stage select bundle between pipeline and forwarding control.
// Latency: n/a (wires only); selects change one cycle after the ID request.
// Backpressure: stall (controller to pipeline) holds PC and IF/ID; freeze holds everything.
interface fwd_sel_ctrl_if;
  import mips_pkg::*;

  logic                freeze;
  logic                flush;
  logic                id_valid;
  logic [REG_ADDR-1:0] id_rs;
  logic [REG_ADDR-1:0] id_rt;
  logic                id_use_rs;
  logic                id_use_rt;
  logic                id_reg_write;
  logic                id_mem_read;
  logic [REG_ADDR-1:0] id_rd;
  logic                stall;
  logic [SEL_W-1:0]    ex_sel_a;
  logic [SEL_W-1:0]    ex_sel_b;
  logic                ex_valid;

  // Pipeline side
  modport master (
    output freeze, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_reg_write, id_mem_read, id_rd,
    input  stall, ex_sel_a, ex_sel_b, ex_valid
  );

  // Controller side
  modport slave (
    input  freeze, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_reg_write, id_mem_read, id_rd,
    output stall, ex_sel_a, ex_sel_b, ex_valid
  );

endinterface

// File: rtl/fwd_match.sv
// Per-source youngest-first compare against EX/MEM(/WB) history; FWD_LATE_BYPASS_EN adds the WB compare.
// Latency: combinational.
// Backpressure: none.
module fwd_match
  import mips_pkg::*;
(
  input  logic                i_use,
  input  logic [REG_ADDR-1:0] i_src,
  input  trk_t                i_ex,
  input  trk_t                i_mem,
`ifdef FWD_LATE_BYPASS_EN
  input  trk_t                i_wb,
`endif
  output logic [SEL_W-1:0]    o_sel
);

  // Load flag is only needed by the stall logic in the parent
  logic w_unused_ld;
  assign w_unused_ld = i_ex.ld ^ i_mem.ld;

  // Youngest producer wins; an unused source always reads the register file
  always_comb begin
    o_sel = SEL_REGFILE;
    if (i_use) begin
      if (trk_hit(i_ex, i_src)) begin
        o_sel = SEL_MEM;
      end else if (trk_hit(i_mem, i_src)) begin
        o_sel = SEL_WB;
`ifdef FWD_LATE_BYPASS_EN
      end else if (trk_hit(i_wb, i_src)) begin
        o_sel = SEL_LATE;
`endif
      end
    end
  end

endmodule

// File: rtl/fwd_sel_ctrl.sv
// MIPS EX operand-mux select generator with load-use stall; FWD_LATE_BYPASS_EN enables the 2'b11 late bypass.
// Latency: selects and ex_valid registered ID->EX (1 cycle); stall is combinational.
// Backpressure: stall holds PC/IF/ID for one cycle per load-use pair; freeze holds all state.
module fwd_sel_ctrl
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fwd_sel_ctrl_if.slave fwd
);

  trk_t             r_ex;
  trk_t             r_mem;
  trk_t             r_wb;
`ifdef FWD_LATE_BYPASS_EN
  trk_t             r_l;
`endif
  logic [SEL_W-1:0] r_sel_a;
  logic [SEL_W-1:0] r_sel_b;

  logic             w_ld_use;
  logic             w_stall;
  logic             w_id_vld;
  trk_t             w_id_ent;
  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;

  // A load in EX cannot feed the ID instruction in time; $0 is exempt
  assign w_ld_use = r_ex.valid & r_ex.ld & (r_ex.rd != '0) &
                    ((fwd.id_use_rs & (r_ex.rd == fwd.id_rs)) |
                     (fwd.id_use_rt & (r_ex.rd == fwd.id_rt)));
  // Flush kills the ID instruction, so it outranks the stall
  assign w_stall  = fwd.id_valid & ~fwd.flush & w_ld_use;
  assign w_id_vld = fwd.id_valid & ~fwd.flush & ~w_stall;

  // Entry entering EX; a bubble carries no write or load
  always_comb begin
    w_id_ent       = TRK_NONE;
    w_id_ent.valid = w_id_vld;
    w_id_ent.wr    = w_id_vld & fwd.id_reg_write;
    w_id_ent.ld    = w_id_vld & fwd.id_mem_read;
    w_id_ent.rd    = fwd.id_rd;
  end

  fwd_match u_match_rs (
    .i_use (fwd.id_use_rs & w_id_vld),
    .i_src (fwd.id_rs),
    .i_ex  (r_ex),
    .i_mem (r_mem),
`ifdef FWD_LATE_BYPASS_EN
    .i_wb  (r_wb),
`endif
    .o_sel (w_sel_a)
  );

  fwd_match u_match_rt (
    .i_use (fwd.id_use_rt & w_id_vld),
    .i_src (fwd.id_rt),
    .i_ex  (r_ex),
    .i_mem (r_mem),
`ifdef FWD_LATE_BYPASS_EN
    .i_wb  (r_wb),
`endif
    .o_sel (w_sel_b)
  );

  // Advance destination history and register selects unless the pipeline is frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex    <= TRK_NONE;
      r_mem   <= TRK_NONE;
      r_wb    <= TRK_NONE;
`ifdef FWD_LATE_BYPASS_EN
      r_l     <= TRK_NONE;
`endif
      r_sel_a <= SEL_REGFILE;
      r_sel_b <= SEL_REGFILE;
    end else if (!fwd.freeze) begin
`ifdef FWD_LATE_BYPASS_EN
      r_l     <= r_wb;
`endif
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      r_ex    <= w_id_ent;
      r_sel_a <= w_sel_a;
      r_sel_b <= w_sel_b;
    end
  end

  assign fwd.stall    = w_stall;
  assign fwd.ex_sel_a = r_sel_a;
  assign fwd.ex_sel_b = r_sel_b;
  assign fwd.ex_valid = r_ex.valid;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Bench for fwd_sel_ctrl: directed hazard scenarios plus a random stream, against a distance-based model.
// Latency: expected EX outputs are queued at drive time and compared one edge later.
// Backpressure: the bench re-presents an ID instruction after a stall, as IF/ID would.
module tb_fwd_sel_ctrl;

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } ent_t;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       v;
  } exp_t;

`ifdef FWD_LATE_BYPASS_EN
  localparam int MAXD = 3;
`else
  localparam int MAXD = 2;
`endif

  logic clk;
  logic rst;
  fwd_sel_ctrl_if fwd ();

  fwd_sel_ctrl dut (
    .clk (clk),
    .rst (rst),
    .fwd (fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk;
  int   n_err;
  ent_t hist [0:2];
  exp_t sb_q [$];
  exp_t cur_exp;
  logic last_stall;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected select = distance (in issued instructions) to the youngest writer of src
  function automatic logic [1:0] model_sel(input logic use_src, input logic [4:0] src);
    if (!use_src || src == 5'd0) return 2'b00;
    for (int d = 0; d < MAXD; d++) begin
      if (hist[d].vld && hist[d].wr && hist[d].rd == src) return 2'(d + 1);
    end
    return 2'b00;
  endfunction

  task automatic go(input logic v, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                    input logic urs, input logic urt, input logic wr, input logic ld,
                    input logic fl, input logic fz, input logic r);
    logic exp_stall;
    logic vld;
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst              = r;
    fwd.freeze       = fz;
    fwd.flush        = fl;
    fwd.id_valid     = v;
    fwd.id_rs        = rs;
    fwd.id_rt        = rt;
    fwd.id_use_rs    = urs;
    fwd.id_use_rt    = urt;
    fwd.id_reg_write = wr;
    fwd.id_mem_read  = ld;
    fwd.id_rd        = rd;
    #1;
    exp_stall = v && !fl && hist[0].vld && hist[0].ld && hist[0].rd != 5'd0 &&
                ((urs && hist[0].rd == rs) || (urt && hist[0].rd == rt));
    last_stall = fwd.stall;
    check("stall", {7'd0, fwd.stall}, {7'd0, exp_stall});
    if (r) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      e = '0;
    end else if (fz) begin
      e = cur_exp;
    end else begin
      vld   = v && !fl && !exp_stall;
      e.a   = vld ? model_sel(urs, rs) : 2'b00;
      e.b   = vld ? model_sel(urt, rt) : 2'b00;
      e.v   = vld;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{vld: vld, wr: vld && wr, ld: vld && ld, rd: rd};
    end
    cur_exp = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 8'd0, 8'd1);
    end else begin
      e   = sb_q.pop_front();
      got = '{a: fwd.ex_sel_a, b: fwd.ex_sel_b, v: fwd.ex_valid};
      check("ex_sel_a", {6'd0, got.a}, {6'd0, e.a});
      check("ex_sel_b", {6'd0, got.b}, {6'd0, e.b});
      check("ex_valid", {7'd0, got.v}, {7'd0, e.v});
    end
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    go(1'b1, rd, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rd, input logic [4:0] rs);
    go(1'b1, rd, rs, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop();
    go(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    cur_exp    = '0;
    last_stall = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
    rst              = 1'b1;
    fwd.freeze       = 1'b0;
    fwd.flush        = 1'b0;
    fwd.id_valid     = 1'b0;
    fwd.id_rs        = '0;
    fwd.id_rt        = '0;
    fwd.id_use_rs    = 1'b0;
    fwd.id_use_rt    = 1'b0;
    fwd.id_reg_write = 1'b0;
    fwd.id_mem_read  = 1'b0;
    fwd.id_rd        = '0;

    // Reset state
    go(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    go(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", {7'd0, fwd.ex_valid}, 8'd0);

    // add $3,$1,$2 ; sub $4,$3,$5
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd4, 5'd3, 5'd5);
    check("d1_sel_a", {6'd0, fwd.ex_sel_a}, 8'h01);
    check("d1_sel_b", {6'd0, fwd.ex_sel_b}, 8'h00);

    // distance 2
    alu(5'd3, 5'd1, 5'd2);
    nop();
    alu(5'd6, 5'd7, 5'd3);
    check("d2_sel_b", {6'd0, fwd.ex_sel_b}, 8'h02);

    // distance 3
    alu(5'd3, 5'd1, 5'd2);
    nop();
    nop();
    alu(5'd6, 5'd7, 5'd3);
`ifdef FWD_LATE_BYPASS_EN
    check("d3_sel_b", {6'd0, fwd.ex_sel_b}, 8'h03);
`else
    check("d3_sel_b", {6'd0, fwd.ex_sel_b}, 8'h00);
`endif

    // lw $8,0($1) ; add $9,$8,$8 (re-presented after the stall)
    lw(5'd8, 5'd1);
    alu(5'd9, 5'd8, 5'd8);
    check("lu_stall", {7'd0, last_stall}, 8'd1);
    check("lu_bubble", {7'd0, fwd.ex_valid}, 8'd0);
    alu(5'd9, 5'd8, 5'd8);
    check("lu_stall_gone", {7'd0, last_stall}, 8'd0);
    check("lu_sel_a", {6'd0, fwd.ex_sel_a}, 8'h02);
    check("lu_sel_b", {6'd0, fwd.ex_sel_b}, 8'h02);

    // $0 never forwards nor stalls
    alu(5'd0, 5'd1, 5'd2);
    alu(5'd5, 5'd0, 5'd0);
    check("r0_sel_a", {6'd0, fwd.ex_sel_a}, 8'h00);
    lw(5'd0, 5'd1);
    alu(5'd5, 5'd0, 5'd0);
    check("r0_no_stall", {7'd0, last_stall}, 8'd0);

    // flush on the load-dependent instruction
    lw(5'd8, 5'd1);
    go(1'b1, 5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("fl_no_stall", {7'd0, last_stall}, 8'd0);
    check("fl_bubble", {7'd0, fwd.ex_valid}, 8'd0);
    nop();

    // freeze for 3 cycles mid-dependency
    alu(5'd3, 5'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      go(1'b1, 5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      check("fz_hold_valid", {7'd0, fwd.ex_valid}, 8'd1);
    end
    alu(5'd4, 5'd3, 5'd5);
    check("fz_resume_a", {6'd0, fwd.ex_sel_a}, 8'h01);

    // reset pulse mid-stream, with a pending load-use
    lw(5'd8, 5'd1);
    go(1'b1, 5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rs_sel_a", {6'd0, fwd.ex_sel_a}, 8'h00);
    check("rs_valid", {7'd0, fwd.ex_valid}, 8'd0);
    alu(5'd9, 5'd8, 5'd8);
    check("rs_stall", {7'd0, last_stall}, 8'd0);

    // random stream over a small register set
    for (int i = 0; i < 300; i++) begin
      go(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
         1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
         1'($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
